// File: rtl/player_input_pkg.sv
// Shared types and constants for the player pushbutton front end.
package player_input_pkg;

    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounceState_t;

endpackage

// File: rtl/player_input_key_channel.sv
// One pushbutton: 2-flop synchronizer, debounce FSM and stability counter.
// pressStrobe is the combinational PRESS_WAIT->PRESSED condition, registered by the top.
module key_channel
    import player_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic Clock,
    input  logic RST,
    input  logic keyN,
    output logic pressStrobe
);

    localparam logic [CNT_WIDTH-1:0] DEBOUNCE_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE        = CNT_WIDTH'(1);

    logic                 syncMeta;
    logic                 syncKey;
    debounceState_t       state;
    debounceState_t       nextState;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] nextCount;

    always_ff @(posedge Clock) begin
        if (RST) begin
            syncMeta <= 1'b1;
            syncKey  <= 1'b1;
            state    <= RELEASED;
            count    <= '0;
        end else begin
            syncMeta <= keyN;
            syncKey  <= syncMeta;
            state    <= nextState;
            count    <= nextCount;
        end
    end

    always_comb begin
        nextState   = state;
        nextCount   = count;
        pressStrobe = 1'b0;
        case (state)
            RELEASED: begin
                if (!syncKey) begin
                    nextState = PRESS_WAIT;
                    nextCount = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                // A level reversal always wins over a count that has just matured.
                if (syncKey) begin
                    nextState = RELEASED;
                    nextCount = '0;
                end else if (count == DEBOUNCE_LIMIT) begin
                    nextState   = PRESSED;
                    nextCount   = '0;
                    pressStrobe = 1'b1;
                end else begin
                    nextCount = count + CNT_ONE;
                end
            end
            PRESSED: begin
                if (syncKey) begin
                    nextState = RELEASE_WAIT;
                    nextCount = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!syncKey) begin
                    nextState = PRESSED;
                    nextCount = '0;
                end else if (count == DEBOUNCE_LIMIT) begin
                    nextState = RELEASED;
                    nextCount = '0;
                end else begin
                    nextCount = count + CNT_ONE;
                end
            end
            default: begin
                nextState = RELEASED;
                nextCount = '0;
            end
        endcase
    end

endmodule

// File: rtl/player_input.sv
// Two debounced pushbuttons arbitrated into mutually exclusive one-cycle move pulses.
module player_input
    import player_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic Clock,
    input  logic RST,
    input  logic KEY_L_n,
    input  logic KEY_R_n,
    output logic L,
    output logic R
);

    logic strobeL;
    logic strobeR;

    key_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) leftKey (
        .Clock      (Clock),
        .RST        (RST),
        .keyN       (KEY_L_n),
        .pressStrobe(strobeL)
    );

    key_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) rightKey (
        .Clock      (Clock),
        .RST        (RST),
        .keyN       (KEY_R_n),
        .pressStrobe(strobeR)
    );

    // Simultaneous presses cancel so downstream cells never see a conflicting move.
    always_ff @(posedge Clock) begin
        if (RST) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= strobeL & ~strobeR;
            R <= strobeR & ~strobeL;
        end
    end

endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input with DEBOUNCE_CYCLES=4 (press latency 6 edges).
module tb_player_input;

    logic Clock = 1'b0;
    logic RST;
    logic KEY_L_n;
    logic KEY_R_n;
    logic L;
    logic R;

    int errors = 0;
    int checks = 0;

    player_input #(.DEBOUNCE_CYCLES(4)) dut (
        .Clock  (Clock),
        .RST    (RST),
        .KEY_L_n(KEY_L_n),
        .KEY_R_n(KEY_R_n),
        .L      (L),
        .R      (R)
    );

    always #5 Clock = ~Clock;

    // Drive keys for the next edge, then check outputs 1 time unit after that edge.
    task automatic cycle(input logic kl, input logic kr, input logic expL, input logic expR,
                         input string tag, input int idx);
        KEY_L_n = kl;
        KEY_R_n = kr;
        @(posedge Clock);
        #1;
        checks++;
        assert (L === expL) else begin
            errors++;
            $error("FAIL %s[%0d] L=%0b expected %0b", tag, idx, L, expL);
        end
        checks++;
        assert (R === expR) else begin
            errors++;
            $error("FAIL %s[%0d] R=%0b expected %0b", tag, idx, R, expR);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, tag, i);
    endtask

    initial begin
        RST     = 1'b1;
        KEY_L_n = 1'b1;
        KEY_R_n = 1'b1;

        // Reset held two cycles, outputs forced low
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "reset", 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "reset", 1);
        RST = 1'b0;
        idle(4, "post_reset");

        // Left press held 20 cycles: single pulse 6 edges after first low sample
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, logic'(i == 6), 1'b0, "left_hold", i);
        idle(12, "left_release");

        // Right bounces 0,0,1,1 for 12 cycles then settles low at index 12
        for (int i = 0; i < 26; i++) begin
            logic kr;
            kr = (i < 12) ? logic'((i / 2) % 2) : 1'b0;
            cycle(1'b1, kr, 1'b0, logic'(i == 18), "right_bounce", i);
        end
        idle(12, "right_release");

        // Both keys on the same edge cancel
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, "both_same", i);
        idle(12, "both_release");

        // Left one edge before right: separate adjacent pulses
        for (int i = 0; i < 20; i++)
            cycle(1'b0, logic'(i < 1), logic'(i == 6), logic'(i == 7), "staggered", i);
        idle(12, "staggered_release");

        // Reset during a hold restarts the debounce from the first post-reset edge
        for (int i = 0; i < 30; i++) begin
            RST = (i == 14);
            cycle(1'b0, 1'b1, logic'(i == 6 || i == 21), 1'b0, "reset_hold", i);
        end
        RST = 1'b0;
        idle(12, "reset_release");

        // Press 10, release 10, press 10: two pulses
        for (int i = 0; i < 30; i++)
            cycle(logic'(i >= 10 && i < 20), 1'b1, logic'(i == 6 || i == 26), 1'b0, "press_twice", i);
        idle(12, "twice_release");

        // 2-cycle release bounce inside a hold adds no pulse
        for (int i = 0; i < 24; i++)
            cycle(logic'(i == 10 || i == 11), 1'b1, logic'(i == 6), 1'b0, "release_bounce", i);
        idle(12, "final_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_input.md
PLAYER_INPUT -- requirements
Module: player_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable cycles needed to accept a key level change; legal range 1..65535.
REQ-002 Clock  input  1  system clock (50 MHz on board); the block SHALL have one clock and SHALL sample all state on its rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 KEY_L_n  input  1  raw left pushbutton, active-low, asynchronous to Clock, may bounce.
REQ-005 KEY_R_n  input  1  raw right pushbutton, active-low, asynchronous to Clock, may bounce.
REQ-006 L  output  1  one-cycle press pulse for the left key; feeds L of every light cell.
REQ-007 R  output  1  one-cycle press pulse for the right key; feeds R of every light cell.

Function
REQ-008 Each key SHALL pass through a 2-flop synchronizer with reset value 1 (released) before any other logic.
REQ-009 Each key SHALL have a debounce FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter 16 bits wide.
REQ-010 RELEASED->PRESS_WAIT SHALL occur when the synced level is 0, with counter = 1.
REQ-011 PRESS_WAIT SHALL increment the counter while the synced level is 0 and SHALL go to PRESSED when the counter reaches DEBOUNCE_CYCLES; a synced 1 SHALL return it to RELEASED with counter 0.
REQ-012 PRESSED->RELEASE_WAIT SHALL occur on synced 1, with counter = 1; RELEASE_WAIT SHALL count synced 1s to DEBOUNCE_CYCLES, then go to RELEASED; a synced 0 SHALL return it to PRESSED with counter 0.
REQ-013 A channel SHALL raise its internal press strobe for exactly the one cycle after the PRESS_WAIT->PRESSED transition; no other transition SHALL produce a strobe.
REQ-014 Latency: raw key held low from the edge at cycle k SHALL give a strobe high in exactly cycle k+2+DEBOUNCE_CYCLES.
REQ-015 A key held indefinitely SHALL produce exactly one strobe (no auto-repeat).
REQ-016 Bounce (level reversal) shorter than DEBOUNCE_CYCLES cycles in either wait state SHALL produce no strobe and no additional strobe.
REQ-017 L and R SHALL be registered outputs: L = left strobe AND NOT right strobe; R = right strobe AND NOT left strobe.
REQ-018 Strobes from both keys in the same cycle SHALL give L=0 and R=0 for that cycle, so downstream cells see no move.
REQ-019 Strobes in different cycles, however close, SHALL each produce their own pulse.
REQ-020 L and R SHALL never both be 1 in the same cycle.

Reset
REQ-021 With RST=1 at a rising edge, on the next cycle both FSMs SHALL be RELEASED, counters 0, synchronizer flops 1, L=0 and R=0.
REQ-022 Reset mid-debounce or mid-hold SHALL discard progress; a key still held after RST deasserts SHALL be treated as a new press and produce one pulse after the full REQ-014 latency, measured from the first post-reset edge.

Structure
REQ-023 Shared package player_input_pkg SHALL hold the debounce state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the counter width constant (16).
REQ-024 Per-key synchronizer, FSM and counter SHALL be sub-module key_channel, instantiated twice; top-level player_input SHALL hold only the arbitration and output registers.

Verification
REQ-025 DEBOUNCE_CYCLES=4, RST 2 cycles, KEY_L_n low from edge 10, held 20 cycles -> L=1 only in cycle 16, R=0 throughout.
REQ-026 KEY_R_n toggles 0/1 every 2 cycles for 12 cycles, then stays 0 -> exactly one R pulse, 6 cycles after the final stable 0 is sampled; no earlier pulse.
REQ-027 KEY_L_n and KEY_R_n go low on the same edge, held -> L=0 and R=0 in every cycle.
REQ-028 KEY_L_n low at edge 10 and KEY_R_n low at edge 11 -> L pulse in cycle 16, R pulse in cycle 17, never overlapping.
REQ-029 Left held, RST asserted in cycle 20 for 1 cycle, key still held -> no pulse while RST is high; one L pulse 6 cycles after the first post-reset edge.
REQ-030 Press-release-press with each phase 10 cycles -> exactly two L pulses; release bounce of 2 cycles inside a hold -> no extra pulse.
